// File: rtl/spi_memory.sv
// SPI slave fronting a 128 x 8 register memory: one command byte (7-bit address + R/W)
// followed by one data byte per chip-select period; the SPI pins are oversampled on clk.
module spi_memory (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic [3:0] leds
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_MEM,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [3:0] bit_cnt;
    logic [6:0] addr;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       armed;
    logic [7:0] mem [0:127];

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_pin};
            cs_sync   <= {cs_sync[0], cs_pin};
            mosi_sync <= {mosi_sync[0], mosi_pin};
            sclk_prev <= sclk_s;
        end
    end

    // armed stays low after reset until cs is seen high, so a transaction cut by reset
    // cannot resume mid-stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            addr      <= 7'd0;
            shift_in  <= 8'd0;
            shift_out <= 8'd0;
            miso_pin  <= 1'b0;
            leds      <= 4'd0;
            armed     <= 1'b0;
        end else if (cs_s) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            miso_pin <= 1'b0;
            armed    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    miso_pin <= 1'b0;
                    if (armed) begin
                        state   <= CMD;
                        bit_cnt <= 4'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_in <= {shift_in[6:0], mosi_s};
                        if (bit_cnt == 4'd7) begin
                            addr    <= shift_in[6:0];
                            bit_cnt <= 4'd0;
                            state   <= mosi_s ? READ_LOAD : WRITE_SHIFT;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                READ_LOAD: begin
                    shift_out <= mem[addr];
                    state     <= READ_SHIFT;
                end
                // D0 is held until the master's next rising edge, then the read retires.
                READ_SHIFT: begin
                    if (sclk_fall && bit_cnt != 4'd8) begin
                        miso_pin  <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end else if (sclk_rise && bit_cnt == 4'd8) begin
                        miso_pin <= 1'b0;
                        state    <= DONE;
                    end
                end
                WRITE_SHIFT: begin
                    if (sclk_rise) begin
                        shift_in <= {shift_in[6:0], mosi_s};
                        if (bit_cnt == 4'd7) begin
                            state <= WRITE_MEM;
                        end
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                WRITE_MEM: begin
                    leds  <= shift_in[3:0];
                    state <= DONE;
                end
                DONE: begin
                    miso_pin <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    miso_pin <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately outside reset; the commit mirrors the FSM's WRITE_MEM step.
    always_ff @(posedge clk) begin
        if (rst_n && !cs_s && state == WRITE_MEM) begin
            mem[addr] <= shift_in;
        end
    end

endmodule

// File: tb/tb_spi_memory.sv
// Scoreboarded bench for spi_memory: a master task drives SPI frames and queues the
// expected MISO bit for every SCLK fall; a monitor pops and compares on each fall.
module tb_spi_memory;

    localparam int HALF = 16;

    logic       clk;
    logic       rst_n;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    bit [7:0] model_mem [128];
    bit       model_written [128];
    bit [3:0] model_leds;
    bit       exp_q [$];

    spi_memory dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One chip-select period of nclk SCLK cycles; rst_at pulses reset after that fall.
    task automatic apply_stimulus(input logic [6:0] a, input logic rw, input logic [7:0] d,
                                  input int nclk, input int rst_at);
        logic [15:0] bits;
        bit          rst_done;
        bit          e;
        bits     = {a, rw, d};
        rst_done = 1'b0;
        cs_pin   = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nclk; i++) begin
            mosi_pin = (i < 16) ? bits[15 - i] : 1'($urandom_range(0, 1));
            wait_clk(HALF);
            sclk_pin = 1'b1;
            wait_clk(HALF);
            e = 1'b0;
            if (rw && !rst_done && i >= 7 && i <= 14)
                e = model_mem[a][14 - i];
            exp_q.push_back(e);
            sclk_pin = 1'b0;
            if (i == rst_at) begin
                wait_clk(8);
                rst_n = 1'b0;
                wait_clk(2);
                rst_n = 1'b1;
                model_leds = 4'd0;
                rst_done   = 1'b1;
                check_output("miso_after_reset", int'(miso_pin), 0);
                check_output("leds_after_reset", int'(leds), 0);
            end
        end
        wait_clk(HALF);
        cs_pin = 1'b1;
        wait_clk(2 * HALF);
        if (!rw && nclk >= 16 && rst_at < 0) begin
            model_mem[a]     = d;
            model_written[a] = 1'b1;
            model_leds       = d[3:0];
        end
    endtask

    initial begin : monitor
        bit e;
        forever begin
            @(negedge sclk_pin);
            if (!cs_pin) begin
                repeat (6) @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL miso_unexpected_fall: got %0b, expected no fall at %0t",
                             miso_pin, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_output("miso_bit", int'(miso_pin), int'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [6:0] a;
        logic       rw;
        logic [7:0] d;
        rst_n      = 1'b0;
        cs_pin     = 1'b1;
        sclk_pin   = 1'b0;
        mosi_pin   = 1'b0;
        model_leds = 4'd0;
        wait_clk(4);
        check_output("reset_miso", int'(miso_pin), 0);
        check_output("reset_leds", int'(leds), 0);
        rst_n = 1'b1;
        wait_clk(4);

        apply_stimulus(7'h61, 1'b0, 8'hB1, 16, -1);
        check_output("leds_wr_b1", int'(leds), int'(model_leds));
        apply_stimulus(7'h61, 1'b1, 8'h00, 16, -1);
        check_output("leds_after_rd", int'(leds), 1);

        apply_stimulus(7'h7E, 1'b0, 8'h3C, 16, -1);
        apply_stimulus(7'h00, 1'b0, 8'hA5, 16, -1);
        apply_stimulus(7'h7E, 1'b1, 8'h00, 16, -1);
        apply_stimulus(7'h00, 1'b1, 8'h00, 16, -1);
        check_output("leds_isolation", int'(leds), int'(model_leds));

        apply_stimulus(7'h10, 1'b0, 8'h55, 16, -1);
        apply_stimulus(7'h10, 1'b0, 8'hFF, 12, -1);
        apply_stimulus(7'h10, 1'b1, 8'h00, 16, -1);
        check_output("leds_abort", int'(leds), 5);

        apply_stimulus(7'h20, 1'b0, 8'h0F, 24, -1);
        apply_stimulus(7'h20, 1'b1, 8'h00, 16, -1);
        check_output("leds_extra_clk", int'(leds), int'(model_leds));

        apply_stimulus(7'h61, 1'b1, 8'h00, 16, 10);
        check_output("leds_post_reset", int'(leds), 0);
        apply_stimulus(7'h61, 1'b1, 8'h00, 16, -1);

        for (int n = 0; n < 20; n++) begin
            a  = 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            if (rw && !model_written[a]) rw = 1'b0;
            apply_stimulus(a, rw, d, 16 + $urandom_range(0, 4), -1);
            check_output("leds_random", int'(leds), int'(model_leds));
        end

        check_output("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_memory.md
SPI_MEMORY -- requirements
Module: spi_memory

Interface
REQ-001 SHALL have no parameters; the memory is fixed at 128 words x 8 bits, with a 7-bit address.
REQ-002 clk  input  1  system clock; all state updates on the rising edge of clk.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 sclk_pin  input  1  SPI serial clock, asynchronous to clk.
REQ-005 cs_pin  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 miso_pin  output  1  SPI serial data out, always driven (no tri-state).
REQ-007 mosi_pin  input  1  SPI serial data in, asynchronous to clk.
REQ-008 leds  output  4  debug display: the low nibble of the most recently written data byte.

Function
REQ-009 Input conditioning: sclk_pin, cs_pin and mosi_pin SHALL each pass through a 2-flop synchronizer on clk.
REQ-010 The synchronized sclk SHALL feed a one-clk-wide rising-edge pulse and a one-clk-wide falling-edge pulse.
REQ-011 Each SCLK high phase and each SCLK low phase SHALL last at least 8 clk cycles; behaviour is undefined otherwise.
REQ-012 Sampling: MOSI SHALL be sampled on SCLK rising-edge pulses only, MSB first.
REQ-013 Command byte: the first 8 MOSI bits after cs falls are addr[6:0] (bits 1-7), followed by the R/W bit (bit 8); 1 = read, 0 = write.
REQ-014 FSM states: IDLE, CMD, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE.
REQ-015 IDLE -> CMD when synchronized cs is low; the bit counter clears on entry to CMD.
REQ-016 CMD -> READ_LOAD (R/W = 1) or WRITE_SHIFT (R/W = 0) after the 8th rising edge.
REQ-017 READ_LOAD: lasts one clk; loads mem[addr] into the output shift register; -> READ_SHIFT.
REQ-018 READ_SHIFT: on each SCLK falling-edge pulse, miso takes the next data bit, MSB first.
REQ-019 READ_SHIFT timing: the first falling edge after the R/W bit presents D7; the 8th presents D0; -> DONE after the 8th falling edge.
REQ-020 WRITE_SHIFT: shifts in 8 MOSI bits (MSB first) on rising edges; -> WRITE_MEM after the 8th.
REQ-021 WRITE_MEM: lasts one clk; writes mem[addr] and updates leds; -> DONE.
REQ-022 DONE: ignores all further SCLK/MOSI activity until cs goes high.
REQ-023 miso SHALL be 0 in every state other than READ_SHIFT, and SHALL hold 0 in READ_SHIFT before its first falling edge.
REQ-024 Abort: synchronized cs high in any state returns to IDLE within 1 clk.
REQ-025 On abort, a partial write SHALL NOT modify memory or leds; a partial read SHALL end and miso returns to 0.
REQ-026 Transactions are independent: each cs-low period carries exactly one command byte plus one data byte.
REQ-027 Address wrap is not applicable (the 7-bit address covers all 128 words); there is no auto-increment.
REQ-028 Memory SHALL be register- or RAM-based with a single synchronous write; a read followed by a write to the same address returns the old data for the read.

Reset
REQ-029 When rst_n = 0 at a clk edge, the following SHALL clear: FSM to IDLE, bit counter 0, shift registers 0, miso 0, leds 0, and the synchronizers to cs = 1, sclk = 0, mosi = 0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no memory write; after reset release, a new transaction requires cs to go high then low.

Verification
REQ-032 Write then read: write 0xB1 to address 0x61 (MOSI 1100001 0 10110001), raise cs, read address 0x61 (MOSI 1100001 1) -> miso sampled after each of the next 8 falling edges = 1,0,1,1,0,0,0,1; leds = 0x1.
REQ-033 Address isolation: write 0x3C to 0x7E and 0xA5 to 0x00 -> reading 0x7E returns 0x3C and reading 0x00 returns 0xA5.
REQ-034 Aborted write: after writing 0x55 to 0x10, start a write of 0xFF to 0x10 and raise cs after 4 data bits -> reading 0x10 returns 0x55; leds = 0x5.
REQ-035 Extra clocks: send 24 SCLK cycles during one write of 0x0F to 0x20 -> only 0x0F is stored at 0x20 and miso stays 0 throughout.
REQ-036 Reset mid-read: pulse rst_n low during READ_SHIFT -> miso = 0, leds = 0, and memory contents are preserved on a subsequent read.
